// File: rtl/monitor_pkg.sv
// Shared types and constants for the sumador stream monitor.
package monitor_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MATCH_W = 4;

  localparam logic [1:0] SEL_SAMPLE = 2'd0;
  localparam logic [1:0] SEL_WRAP   = 2'd1;
  localparam logic [1:0] SEL_ERR    = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  localparam int unsigned STAT_LOCKED_BIT = 7;
  localparam int unsigned STAT_STATE_LSB  = 5;
  localparam int unsigned STAT_MATCH_LSB  = 0;

  // Status byte: {locked, state[1:0], 1'b0, match_cnt[3:0]}
  function automatic logic [DATA_W-1:0] status_byte(input logic locked,
                                                    input state_e st,
                                                    input logic [MATCH_W-1:0] mc);
    logic [DATA_W-1:0] s;
    s = '0;
    s[STAT_LOCKED_BIT] = locked;
    s[STAT_STATE_LSB +: 2] = st;
    s[STAT_MATCH_LSB +: MATCH_W] = mc;
    return s;
  endfunction

endpackage

// File: rtl/monitor_sumador_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/monitor_sumador.sv
// Receive-side checker for the 8-bit sumador stream: lock, wrap counting, error flagging.
module monitor_sumador
  import monitor_pkg::*;
#(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned WRAP_W = 16,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        count_in,
  input  logic              carry_in,
  input  logic              en_in,
  input  logic              clr,
  input  logic [1:0]        sel,
  output logic [7:0]        data_out,
  output logic              locked,
  output logic              err_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  state_e               state_q, state_d;
  logic [7:0]           prev_val_q, prev_val_d;
  logic                 prev_en_q, prev_en_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
  logic [MATCH_W-1:0]   match_inc;
  logic                 err_pulse_q, err_pulse_d;
  logic                 locked_q, locked_d;
  logic [7:0]           exp_val;
  logic                 cexp;
  logic                 mismatch;
  logic                 wrap_inc, err_inc;

  // Prediction from the previous sample
  assign exp_val   = prev_val_q + 8'(prev_en_q);
  assign cexp      = prev_en_q && (prev_val_q == 8'hFF);
  assign mismatch  = (count_in != exp_val) || (carry_in != cexp);
  assign match_inc = match_cnt_q + MATCH_W'(1);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_pulse_d = 1'b0;
    wrap_inc    = 1'b0;
    err_inc     = 1'b0;
    prev_val_d  = count_in;
    prev_en_d   = en_in;
    case (state_q)
      ST_UNLOCKED: begin
        state_d     = ST_ACQUIRE;
        match_cnt_d = '0;
      end
      ST_ACQUIRE: begin
        if (mismatch) begin
          match_cnt_d = '0;
        end else if (match_inc == MATCH_W'(LOCK_N)) begin
          state_d     = ST_LOCKED;
          match_cnt_d = '0;
        end else begin
          match_cnt_d = match_inc;
        end
      end
      ST_LOCKED: begin
        if (mismatch) begin
          err_pulse_d = 1'b1;
          err_inc     = 1'b1;
          state_d     = ST_ACQUIRE;
          match_cnt_d = '0;
        end else if (cexp) begin
          wrap_inc = 1'b1;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      prev_val_q  <= '0;
      prev_en_q   <= 1'b0;
      match_cnt_q <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_val_q  <= prev_val_d;
      prev_en_q   <= prev_en_d;
      match_cnt_q <= match_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap_inc),
    .clr (clr),
    .cnt (wrap_cnt)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (clr),
    .cnt (err_cnt)
  );

  // Readout mux straight from registered state
  always_comb begin
    case (sel)
      SEL_SAMPLE: data_out = prev_val_q;
      SEL_WRAP:   data_out = wrap_cnt[7:0];
      SEL_ERR:    data_out = err_cnt[7:0];
      default:    data_out = status_byte(locked_q, state_q, match_cnt_q);
    endcase
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_monitor_sumador.sv
// Directed self-checking bench for monitor_sumador.
module tb_monitor_sumador;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  count_in;
  logic        carry_in;
  logic        en_in;
  logic        clr;
  logic [1:0]  sel;
  logic [7:0]  data_out;
  logic        locked;
  logic        err_pulse;
  logic [15:0] wrap_cnt;
  logic [7:0]  err_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] cur = 8'd0;

  always #5 clk = ~clk;

  monitor_sumador #(.LOCK_N(4), .WRAP_W(16), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .carry_in  (carry_in),
    .en_in     (en_in),
    .clr       (clr),
    .sel       (sel),
    .data_out  (data_out),
    .locked    (locked),
    .err_pulse (err_pulse),
    .wrap_cnt  (wrap_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic drive(input logic [7:0] v, input logic e, input logic c);
    count_in = v;
    en_in    = e;
    carry_in = c;
    @(posedge clk);
    #1;
  endtask

  // Clean incrementing source, carry asserted on the 255->0 step
  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) begin
      cur = 8'(cur + 8'd1);
      drive(cur, 1'b1, cur == 8'd0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; sel = 2'd0;
    drive(8'd0, 1'b0, 1'b0);
    drive(8'd0, 1'b0, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got=%0b exp=0", err_pulse); end
    checks++; if (wrap_cnt !== 16'd0) begin errors++; $display("FAIL reset_wrap got=%0d exp=0", wrap_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
    checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL reset_sample got=%0h exp=0", data_out); end
    sel = 2'd3; #1;
    checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL reset_status got=%0h exp=0", data_out); end
  endtask

  task automatic test_lock;
    rst = 1'b0;
    cur = 8'd9;
    ramp(3);
    checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL acq_status got=%0h exp=22", data_out); end
    ramp(1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got=%0b exp=0", locked); end
    ramp(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_5th got=%0b exp=1", locked); end
    checks++; if (data_out !== 8'hC0) begin errors++; $display("FAIL lock_status got=%0h exp=c0", data_out); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL lock_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_wrap;
    ramp(241);
    checks++; if (wrap_cnt !== 16'd0) begin errors++; $display("FAIL wrap_pre got=%0d exp=0", wrap_cnt); end
    ramp(1);
    checks++; if (wrap_cnt !== 16'd1) begin errors++; $display("FAIL wrap_first got=%0d exp=1", wrap_cnt); end
    ramp(512);
    checks++; if (wrap_cnt !== 16'd3) begin errors++; $display("FAIL wrap_three got=%0d exp=3", wrap_cnt); end
    sel = 2'd1; #1;
    checks++; if (data_out !== 8'h03) begin errors++; $display("FAIL wrap_sel1 got=%0h exp=03", data_out); end
    checks++; if (err_cnt !== 8'd0 || locked !== 1'b1) begin errors++; $display("FAIL wrap_clean err=%0d locked=%0b exp 0/1", err_cnt, locked); end
  endtask

  task automatic test_seq_error;
    ramp(37);
    cur = 8'd40;
    drive(cur, 1'b1, 1'b0);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL seq_pulse got=%0b exp=1", err_pulse); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL seq_errcnt got=%0d exp=1", err_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL seq_unlock got=%0b exp=0", locked); end
    sel = 2'd3;
    ramp(1);
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL seq_pulse_end got=%0b exp=0", err_pulse); end
    checks++; if (data_out !== 8'h21) begin errors++; $display("FAIL seq_status got=%0h exp=21", data_out); end
    ramp(2);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL seq_relock_early got=%0b exp=0", locked); end
    ramp(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL seq_relock got=%0b exp=1", locked); end
  endtask

  task automatic test_carry_error;
    clr = 1'b1;
    ramp(1);
    clr = 1'b0;
    checks++; if (err_cnt !== 8'd0 || wrap_cnt !== 16'd0) begin errors++; $display("FAIL clr_counts err=%0d wrap=%0d exp 0/0", err_cnt, wrap_cnt); end
    ramp(54);
    cur = 8'd100;
    drive(cur, 1'b1, 1'b1);
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL carryA_err got=%0d exp=1", err_cnt); end
    ramp(4);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL carryA_relock got=%0b exp=1", locked); end
    ramp(151);
    cur = 8'd0;
    drive(cur, 1'b1, 1'b0);
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL carryB_err got=%0d exp=2", err_cnt); end
    checks++; if (wrap_cnt !== 16'd0) begin errors++; $display("FAIL carryB_wrap got=%0d exp=0", wrap_cnt); end
    ramp(4);
  endtask

  task automatic test_enable_hold;
    ramp(72);
    sel = 2'd0;
    cur = 8'd77;
    for (int i = 0; i < 6; i++) begin
      drive(cur, i == 5, 1'b0);
      checks++;
      if (locked !== 1'b1 || err_pulse !== 1'b0 || data_out !== 8'd77) begin
        errors++;
        $display("FAIL hold_%0d locked=%0b pulse=%0b data=%0d exp 1/0/77", i, locked, err_pulse, data_out);
      end
    end
    ramp(1);
    checks++; if (err_cnt !== 8'd2 || wrap_cnt !== 16'd0) begin errors++; $display("FAIL hold_counts err=%0d wrap=%0d exp 2/0", err_cnt, wrap_cnt); end
  endtask

  task automatic test_clr_priority;
    ramp(177);
    clr = 1'b1;
    ramp(1);
    clr = 1'b0;
    checks++; if (wrap_cnt !== 16'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL clrwin wrap=%0d err=%0d exp 0/0", wrap_cnt, err_cnt); end
    ramp(256);
    checks++; if (wrap_cnt !== 16'd1) begin errors++; $display("FAIL clrwin_next got=%0d exp=1", wrap_cnt); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      cur = 8'(cur + 8'd2);
      drive(cur, 1'b1, 1'b0);
      if (i == 253) begin
        checks++; if (err_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got=%0d exp=254", err_cnt); end
      end
      ramp(4);
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_max got=%0d exp=255", err_cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got=%0b exp=1", locked); end
    clr = 1'b1;
    cur = 8'(cur + 8'd2);
    drive(cur, 1'b1, 1'b0);
    clr = 1'b0;
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_err_pulse got=%0b exp=1", err_pulse); end
    ramp(4);
  endtask

  task automatic test_reset_midlock;
    cur = 8'(cur + 8'd2);
    drive(cur, 1'b1, 1'b0);
    ramp(4);
    checks++; if (err_cnt !== 8'd1 || locked !== 1'b1) begin errors++; $display("FAIL prerst err=%0d locked=%0b exp 1/1", err_cnt, locked); end
    rst = 1'b1;
    ramp(1);
    rst = 1'b0;
    sel = 2'd0; #1;
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || wrap_cnt !== 16'd0 || err_cnt !== 8'd0 || data_out !== 8'd0) begin
      errors++;
      $display("FAIL midrst locked=%0b pulse=%0b wrap=%0d err=%0d data=%0h exp all 0", locked, err_pulse, wrap_cnt, err_cnt, data_out);
    end
    sel = 2'd3; #1;
    checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL midrst_status got=%0h exp=0", data_out); end
    ramp(4);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reacq_early got=%0b exp=0", locked); end
    ramp(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reacq got=%0b exp=1", locked); end
  endtask

  initial begin
    count_in = 8'd0; carry_in = 1'b0; en_in = 1'b0;
    test_reset();
    test_lock();
    test_wrap();
    test_seq_error();
    test_carry_error();
    test_enable_hold();
    test_clr_priority();
    test_saturation();
    test_reset_midlock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/monitor_sumador.md
Name: monitor_sumador

Overview:
Receive-side checker for the 8-bit enable-driven up-counter (sumador) stream and its carry-out. It samples the counter value, carry and enable every cycle and predicts the next value. It locks onto the sequence, counts wrap-arounds, and flags and counts sequence or carry errors. A byte-wide readout mux lets the tile top drive results onto the dedicated outputs.

Parameters:
LOCK_N, 4, consecutive correct predictions required to enter LOCKED (range 1..15)
WRAP_W, 16, width of the wrap-around counter (saturating)
ERR_W, 8, width of the error counter (saturating)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
count_in  in  8  counter value from source
carry_in  in  1  source carry-out; high only in the cycle count_in shows 0 after 255
en_in  in  1  source enable; high at cycle t means count_in(t+1) = count_in(t)+1 mod 256
clr  in  1  synchronous clear of wrap_cnt/err_cnt only; FSM untouched
sel  in  2  readout select
data_out  out  8  readout: 0=last sample, 1=wrap_cnt[7:0], 2=err_cnt[7:0], 3=status
locked  out  1  high while FSM in LOCKED
err_pulse  out  1  one-cycle pulse per detected error
wrap_cnt  out  WRAP_W  wraps seen while LOCKED, saturates at all-ones
err_cnt  out  ERR_W  errors seen, saturates at all-ones

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in UNLOCKED.
  - prev_val=0, prev_en=0, match_cnt=0.
- Sample registers, updated every cycle: prev_val<=count_in; prev_en<=en_in.
- Prediction, 8-bit mod 256: exp = prev_val + prev_en.
- Carry predicted (cexp) iff prev_en=1 and prev_val=255.
- Mismatch condition: count_in != exp or carry_in != cexp.
- FSM:
  - UNLOCKED: capture sample (regs above), then go to ACQUIRE next cycle; no checking.
  - ACQUIRE:
    - Match -> match_cnt++.
    - When match_cnt reaches LOCK_N -> LOCKED, match_cnt=0.
    - Mismatch -> match_cnt=0, stay in ACQUIRE (silent, no error counted).
  - LOCKED:
    - Match with cexp=1 -> wrap_cnt++ (saturating).
    - Mismatch -> err_pulse=1 next cycle, err_cnt++ (saturating), go to ACQUIRE with match_cnt=0.
- Latency: err_pulse, locked, and counter updates are registered, visible one cycle after the offending sample.
- data_out is combinational from registered state and sel.
- Status byte: {locked, state[1:0], 1'b0, match_cnt[3:0]}.
- State encoding: UNLOCKED=0, ACQUIRE=1, LOCKED=2.
- Simultaneous events:
  - clr and an increment in the same cycle -> clr wins; counter = 0.
  - clr does not suppress err_pulse.
- rst takes priority over everything and may occur mid-lock. After reset, re-acquisition needs 1 + LOCK_N samples.
- en_in low while LOCKED: a repeated value is a match; no wrap is counted.
- Saturation: wrap_cnt and err_cnt hold at max; no rollover.

Decomposition:
- Shared package monitor_pkg holds:
  - state typedef (UNLOCKED/ACQUIRE/LOCKED) and encodings;
  - SEL_* readout constants;
  - status-byte bit positions.
- One natural sub-module: sat_counter (width parameter, inc, clr, sync rst), instantiated twice for wrap_cnt and err_cnt.

Test Plan:
- Lock-in: rst 2 cycles, then en_in=1 with clean ramp 10,11,12,... -> locked=1 one cycle after the 5th sample (1 capture + LOCK_N=4); err_cnt=0.
- Wrap: locked, ramp 250..255,0 with carry_in=1 at 0 -> wrap_cnt=1; repeat for 3 wraps -> wrap_cnt=3, sel=1 gives data_out=0x03.
- Sequence error: locked, inject 40 after 37 -> err_pulse one cycle, err_cnt=1, locked=0; clean ramp resumes -> relock after 4 matches.
- Carry error:
  - Case A: locked, carry_in=1 at count_in=100 -> err_cnt=1.
  - Case B: carry_in missing at 255->0 -> err_cnt=2, wrap_cnt unchanged.
- Enable hold: locked, en_in=0 for 5 cycles with count steady at 77 -> no error, locked stays 1; sel=0 gives 77.
- Saturation/clr/reset:
  - Force 300 errors -> err_cnt=255.
  - clr together with an error -> err_cnt=0, err_pulse=1.
  - rst mid-lock -> all outputs 0 next cycle.
